des_sbox_hash_stream: RTL
=========================

# des_sbox_hash_stream

Parametrised, streaming successor to the fixed 4-round DES-S-box nibble hash core. It absorbs a message one byte at a time over a valid/ready handshake, applying one round per clock. It counts the message length internally, so no up-front length is needed, and finalises on a `last` flag. It presents a 32-bit digest over a valid/ready output handshake and sits between the byte-stream front end and the digest consumer.

## Interface
- `ROUNDS`, default 4: rounds applied per message byte; legal range 1..16.
- `LEN_W`, default 64: internal byte-length counter width; multiple of 8, range 8..64.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `msg_valid`  in  1  `msg_byte`, `msg_last` and `msg_empty` are valid.
- `msg_ready`  out  1  core can accept a byte; equals `!rst && state==IDLE`.
- `msg_byte`  in  8  message byte.
- `msg_last`  in  1  this transfer ends the message.
- `msg_empty`  in  1  with `msg_last`: zero-length message, so `msg_byte` is ignored. Ignored when `msg_last=0`.
- `digest_out`  out  32  hash; nibble H[i] is at bits [4i+3:4i].
- `digest_valid`  out  1  `digest_out` is valid; held until accepted.
- `digest_ready`  in  1  consumer accepts the digest.
- `msg_len`  out  `LEN_W`  bytes absorbed in the current message.

## Operation
- Initial value: INIT = 32'h4B71DF03, i.e. H[7]=4, H[6]=B, H[5]=7, H[4]=1, H[3]=D, H[2]=F, H[1]=0, H[0]=3.
- S(x): DES S-box 5. The row is {x[5],x[0]} and the column is x[4:1]. Row 0 reads 2,C,4,1,7,A,B,6,8,5,3,F,D,0,E,9.
- Byte compression: M6 = {m3^m2, m1, m0, m7, m6, m5^m4}.
- Round: H'[i] = rotl4(H[(i+1) mod 8] ^ S(M6), floor(i/2)), where rotl4 is a 4-bit rotate left.
- Finalisation:
  - L = `msg_len` zero-extended to 64 bits; byte b_i = L[8i+7:8i].
  - C6(b) = {b7^b1, b3, b2, b5^b0, b4, b6}.
  - D[i] = rotl4(H[(i+1) mod 8] ^ S(C6(b_i)), floor(i/2)).
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE, on accept (`msg_valid && msg_ready`):
    - If `msg_last && msg_empty`: go to FINAL; H and `msg_len` are unchanged.
    - Otherwise: latch S(M6) and `msg_last`; `msg_len` += 1; round counter = 0; go to ROUND.
  - ROUND: each cycle H <= round(H); counter += 1. At counter == `ROUNDS`-1, go to FINAL if the latched last flag is set, else IDLE.
  - FINAL: `digest_out` <= D; `digest_valid` <= 1; go to DONE.
  - DONE: on `digest_ready`, `digest_valid` <= 0, H <= INIT, `msg_len` <= 0, go to IDLE. Otherwise hold.
- `msg_len` wraps modulo 2^`LEN_W`; there is no error flag.

## Timing
- Reset state: IDLE, H=INIT, `msg_len`=0, `digest_out`=0, `digest_valid`=0. `msg_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-message or in DONE discards all state; any pending digest is lost.
- Byte throughput: one byte per `ROUNDS`+1 cycles. `msg_ready` is low for `ROUNDS` cycles after each accept.
- Latency: `digest_valid` rises `ROUNDS`+2 edges after the accept edge of the last byte, or 2 edges after an empty-message accept.
- `digest_out` changes only on the FINAL edge; it is stable throughout DONE and after acceptance.
- `msg_ready`=0 in ROUND, FINAL and DONE. A `msg_valid` held in DONE is accepted in the IDLE cycle after the digest handshake.
- `digest_ready` outside DONE has no effect.
- Back-to-back messages are supported with no dead cycle beyond the DONE→IDLE transition.

## Structure
- Package `des_sbox_hash_pkg` contains:
  - INIT constant;
  - state enum;
  - functions `sbox5`, `m6_compress`, `c6_compress`, `rotl4`, `hash_round(h, s)`.
- Sub-module `des_sbox_hash_final`: combinational finalisation from (H, L) to D, with eight `sbox5`/`c6_compress` lanes.
- Top holds the FSM, round counter, length counter and output registers.

## Test plan
- Empty message (`msg_last`=1, `msg_empty`=1) at `ROUNDS`=4 → `digest_out`=32'h83656FD2, `digest_valid` 2 cycles after accept, `msg_len`=0.
- Single byte 8'h61 with last, `ROUNDS`∈{1,4,16} → `digest_out` equals the golden model; `digest_valid` at `ROUNDS`+2 edges; `msg_ready` low for exactly `ROUNDS` cycles.
- 300-byte random stream with random `msg_valid` gaps → digest equals the golden model; `msg_len`=300 at FINAL.
- Hold `digest_ready`=0 for 10 cycles with `msg_valid`=1 pending → `digest_out` and `digest_valid` are stable; the pending byte is accepted only after the handshake; the second message's digest equals the golden model from INIT.
- `LEN_W`=8 with a 257-byte message → finalisation uses L=1 and the digest matches the golden model for the wrapped length.
- Assert `rst` for one cycle in mid-ROUND, then send the empty message → outputs take reset values immediately and the digest is 32'h83656FD2.

Source files
------------

// File: rtl/des_sbox_hash_stream_pkg.sv
// Shared types and arithmetic for the streaming DES-S5 nibble hash:
// initial value, FSM states and the per-round / finalisation helpers.
package des_sbox_hash_pkg;

    localparam logic [31:0] INIT = 32'h4B71DF03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // DES S5 rows, column c in nibble [4c+3:4c]
    localparam logic [63:0] S5_ROW0 = 64'h9E0D_F358_6BA7_14C2;
    localparam logic [63:0] S5_ROW1 = 64'h6893_AF05_1D74_C2BE;
    localparam logic [63:0] S5_ROW2 = 64'hE036_5C9F_87DA_B124;
    localparam logic [63:0] S5_ROW3 = 64'h354A_90F6_D2E1_7C8B;

    function automatic logic [3:0] sbox5(input logic [5:0] x);
        logic [63:0] row;
        case ({x[5], x[0]})
            2'd0:    row = S5_ROW0;
            2'd1:    row = S5_ROW1;
            2'd2:    row = S5_ROW2;
            default: row = S5_ROW3;
        endcase
        return row[{x[4:1], 2'b00} +: 4];
    endfunction

    function automatic logic [5:0] m6_compress(input logic [7:0] m);
        return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
    endfunction

    function automatic logic [5:0] c6_compress(input logic [7:0] b);
        return {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] n);
        logic [7:0] t;
        t = {x, x} << n;
        return t[7:4];
    endfunction

    function automatic logic [31:0] hash_round(input logic [31:0] h, input logic [3:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = rotl4(h[4*((i + 1) % 8) +: 4] ^ s, 2'(i / 2));
        end
        return r;
    endfunction

endpackage

// File: rtl/des_sbox_hash_stream_if.sv
// Byte-stream input and digest output handshakes of the hash core.
interface des_sbox_hash_stream_if #(
    parameter int LEN_W = 64
);
    logic             msg_valid;
    logic             msg_ready;
    logic [7:0]       msg_byte;
    logic             msg_last;
    logic             msg_empty;
    logic [31:0]      digest_out;
    logic             digest_valid;
    logic             digest_ready;
    logic [LEN_W-1:0] msg_len;

    modport master (
        output msg_valid, msg_byte, msg_last, msg_empty, digest_ready,
        input  msg_ready, digest_out, digest_valid, msg_len
    );

    modport slave (
        input  msg_valid, msg_byte, msg_last, msg_empty, digest_ready,
        output msg_ready, digest_out, digest_valid, msg_len
    );
endinterface

// File: rtl/des_sbox_hash_final.sv
// Combinational finalisation: folds each byte of the 64-bit length into
// one nibble lane of the chaining value.
module des_sbox_hash_final
    import des_sbox_hash_pkg::*;
(
    input  logic [31:0] h,
    input  logic [63:0] len,
    output logic [31:0] digest
);
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [3:0] s_lane;
            assign s_lane = sbox5(c6_compress(len[8*gi +: 8]));
            assign digest[4*gi +: 4] = rotl4(h[4*((gi + 1) % 8) +: 4] ^ s_lane, 2'(gi / 2));
        end
    endgenerate
endmodule

// File: rtl/des_sbox_hash_stream.sv
// Streaming DES-S5 nibble hash: absorbs one byte per ROUNDS+1 cycles,
// counts the length itself and finalises on msg_last.
module des_sbox_hash_stream
    import des_sbox_hash_pkg::*;
#(
    parameter int ROUNDS = 4,
    parameter int LEN_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    des_sbox_hash_stream_if.slave bus
);
    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    state_t           state_reg,  state_next;
    logic [31:0]      h_reg,      h_next;
    logic [3:0]       s_reg,      s_next;
    logic             last_reg,   last_next;
    logic [3:0]       cnt_reg,    cnt_next;
    logic [LEN_W-1:0] len_reg,    len_next;
    logic [31:0]      digest_reg, digest_next;
    logic             dvalid_reg, dvalid_next;
    logic [31:0]      final_digest;

    des_sbox_hash_final u_final (
        .h      (h_reg),
        .len    (64'(len_reg)),
        .digest (final_digest)
    );

    always_comb begin
        state_next  = state_reg;
        h_next      = h_reg;
        s_next      = s_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        len_next    = len_reg;
        digest_next = digest_reg;
        dvalid_next = dvalid_reg;
        case (state_reg)
            IDLE: begin
                if (bus.msg_valid) begin
                    // An empty terminator finalises whatever has been absorbed so far
                    if (bus.msg_last && bus.msg_empty) begin
                        state_next = FINAL;
                    end else begin
                        s_next     = sbox5(m6_compress(bus.msg_byte));
                        last_next  = bus.msg_last;
                        len_next   = len_reg + LEN_W'(1);
                        cnt_next   = '0;
                        state_next = ROUND;
                    end
                end
            end
            ROUND: begin
                h_next   = hash_round(h_reg, s_reg);
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = last_reg ? FINAL : IDLE;
                end
            end
            FINAL: begin
                digest_next = final_digest;
                dvalid_next = 1'b1;
                state_next  = DONE;
            end
            DONE: begin
                if (bus.digest_ready) begin
                    dvalid_next = 1'b0;
                    h_next      = INIT;
                    len_next    = '0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            h_reg      <= INIT;
            s_reg      <= '0;
            last_reg   <= 1'b0;
            cnt_reg    <= '0;
            len_reg    <= '0;
            digest_reg <= '0;
            dvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            h_reg      <= h_next;
            s_reg      <= s_next;
            last_reg   <= last_next;
            cnt_reg    <= cnt_next;
            len_reg    <= len_next;
            digest_reg <= digest_next;
            dvalid_reg <= dvalid_next;
        end
    end

    assign bus.msg_ready    = !rst && (state_reg == IDLE);
    assign bus.digest_out   = digest_reg;
    assign bus.digest_valid = dvalid_reg;
    assign bus.msg_len      = len_reg;
endmodule
